// File: rtl/fpu16_issue_stage.sv
// FP16 issue stage: request FIFO feeding a combinational FP16 add/sub datapath,
// with a registered result slot. Op encoding: ADD=0 SUB=1 MUL=2 DIV=3 SHL=4 SHR=5.

// Combinational FP16 adder/subtractor with round-to-nearest-even.
// cond_codes = {nan, inf, neg, zero}, derived from the final result.
module fpu16 (
   input  logic        sub,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] result,
   output logic [3:0]  cond_codes
);
   logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
   logic        s_big, s_small, up, res_nan;
   logic [4:0]  xa, xb, ea, eb, e_big, e_small, d, msb, lz, lim, sh;
   logic [3:0]  d_cap;
   logic [10:0] ma, mb, m_big, m_small;
   logic [27:0] wide;
   logic [13:0] al, m;
   logic [14:0] s;
   logic [5:0]  e, e_m1;
   logic [11:0] mant_r;
   logic [16:0] mag;

   always_comb begin
      sa    = a[15];
      sb    = b[15] ^ sub;
      xa    = a[14:10];
      xb    = b[14:10];
      a_nan = (&xa) && (|a[9:0]);
      b_nan = (&xb) && (|b[9:0]);
      a_inf = (&xa) && !(|a[9:0]);
      b_inf = (&xb) && !(|b[9:0]);
      // Subnormals use exponent 1 with no hidden bit
      ea    = (xa == 5'd0) ? 5'd1 : xa;
      eb    = (xb == 5'd0) ? 5'd1 : xb;
      ma    = {xa != 5'd0, a[9:0]};
      mb    = {xb != 5'd0, b[9:0]};
      swap  = b[14:0] > a[14:0];
      s_big   = swap ? sb : sa;
      s_small = swap ? sa : sb;
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      m_big   = swap ? mb : ma;
      m_small = swap ? ma : mb;
      d       = e_big - e_small;
      d_cap   = (d > 5'd15) ? 4'd15 : d[3:0];
      // Align the smaller operand keeping guard, round and sticky bits
      wide    = {m_small, 17'd0} >> d_cap;
      al      = {wide[27:15], wide[14] | (|wide[13:0])};
      if (s_big == s_small)
         s = {1'b0, m_big, 3'b000} + {1'b0, al};
      else
         s = {1'b0, m_big, 3'b000} - {1'b0, al};
      msb = 5'd0;
      for (int i = 0; i < 14; i++)
         if (s[i]) msb = 5'(i);
      lz  = 5'd13 - msb;
      lim = e_big - 5'd1;
      sh  = (lz < lim) ? lz : lim;
      if (s[14]) begin
         m = {s[14:2], |s[1:0]};
         e = {1'b0, e_big} + 6'd1;
      end else begin
         m = s[13:0] << sh;
         e = {1'b0, e_big} - {1'b0, sh};
      end
      up     = m[2] & (m[3] | m[1] | m[0]);
      mant_r = {1'b0, m[13:3]} + {11'd0, up};
      // Hidden bit of mant_r carries into the exponent field; e==1 covers subnormals
      e_m1   = e - 6'd1;
      mag    = {1'b0, e_m1, 10'd0} + {5'd0, mant_r};

      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
         result = 16'h7E00;
      else if (a_inf)
         result = {sa, 15'h7C00};
      else if (b_inf)
         result = {sb, 15'h7C00};
      else if (s == 15'd0)
         result = {sa & sb, 15'd0};
      else if (mag >= 17'h07C00)
         result = {s_big, 15'h7C00};
      else
         result = {s_big, mag[14:0]};

      res_nan    = (&result[14:10]) && (|result[9:0]);
      cond_codes = {res_nan,
                    result[14:0] == 15'h7C00,
                    result[15] & ~res_nan,
                    result[14:0] == 15'd0};
   end
endmodule

module fpu16_issue_stage #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                         clock,
   input  logic                         reset_L,
   input  logic                         inValid,
   output logic                         inReady,
   input  logic [2:0]                   op,
   input  logic [15:0]                  fpuIn1,
   input  logic [15:0]                  fpuIn2,
   input  logic [TAG_W-1:0]             tagIn,
   output logic                         outValid,
   input  logic                         outReady,
   output logic [15:0]                  fpuOut,
   output logic [3:0]                   condCodes,
   output logic [TAG_W-1:0]             tagOut,
   output logic                         outErr,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [2:0] FPU_ADD = 3'd0;
   localparam logic [2:0] FPU_SUB = 3'd1;

   logic [2:0]       q_op  [DEPTH];
   logic [15:0]      q_a   [DEPTH];
   logic [15:0]      q_b   [DEPTH];
   logic [TAG_W-1:0] q_tag [DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             accept_en, full, empty, push, pop, slot_free, supported;
   logic [2:0]       head_op;
   logic [15:0]      fpu_res;
   logic [3:0]       fpu_cc;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never depends on ready, and the producer holds its payload until taken.
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign inReady   = accept_en && !full;
   assign push      = inValid && inReady;
   assign slot_free = !outValid || outReady;
   assign pop       = slot_free && !empty;
   assign head_op   = q_op[rd_ptr];
   assign supported = (head_op == FPU_ADD) || (head_op == FPU_SUB);
   assign occupancy = count;

   fpu16 u_fpu (
      .sub        (head_op == FPU_SUB),
      .a          (q_a[rd_ptr]),
      .b          (q_b[rd_ptr]),
      .result     (fpu_res),
      .cond_codes (fpu_cc)
   );

   // Storage needs no reset: entries are only read below the write pointer
   always_ff @(posedge clock) begin
      if (push) begin
         q_op[wr_ptr]  <= op;
         q_a[wr_ptr]   <= fpuIn1;
         q_b[wr_ptr]   <= fpuIn2;
         q_tag[wr_ptr] <= tagIn;
      end
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         accept_en <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         outValid  <= 1'b0;
         fpuOut    <= 16'h0000;
         condCodes <= 4'h0;
         tagOut    <= '0;
         outErr    <= 1'b0;
      end else begin
         accept_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (pop) begin
            outValid  <= 1'b1;
            fpuOut    <= supported ? fpu_res : 16'h0000;
            condCodes <= supported ? fpu_cc : 4'h0;
            tagOut    <= q_tag[rd_ptr];
            outErr    <= !supported;
         end else if (slot_free) begin
            outValid  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fpu16_issue_stage.sv
// Bench for fpu16_issue_stage: real-arithmetic FP16 model feeding an expected
// queue, a negedge compare process, and directed scenarios with literal checks.
module tb_fpu16_issue_stage;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int W     = 1 + TAG_W + 4 + 16;
   localparam int NV    = 18;

   logic              clock, reset_L, inValid, inReady, outValid, outReady, outErr;
   logic [2:0]        op;
   logic [15:0]       fpuIn1, fpuIn2, fpuOut;
   logic [TAG_W-1:0]  tagIn, tagOut;
   logic [3:0]        condCodes;
   logic [2:0]        occupancy;

   logic [W-1:0]      exp_q[$];
   int                checks = 0;
   int                errors = 0;
   int                xfer_count = 0;
   logic              stall_prev = 1'b0;
   logic [W:0]        snap;

   logic [2:0]  v_op  [NV];
   logic [15:0] v_a   [NV];
   logic [15:0] v_b   [NV];
   logic [15:0] v_res [NV];
   logic [3:0]  v_cc  [NV];
   logic        v_err [NV];

   fpu16_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clock(clock), .reset_L(reset_L), .inValid(inValid), .inReady(inReady),
      .op(op), .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .tagIn(tagIn),
      .outValid(outValid), .outReady(outReady), .fpuOut(fpuOut),
      .condCodes(condCodes), .tagOut(tagOut), .outErr(outErr), .occupancy(occupancy)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
      end
   endtask

   // model
   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real to_real(input logic [15:0] h);
      real v;
      if (h[14:10] == 5'd0) v = real'(int'(h[9:0])) * pow2(-24);
      else v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [14:0] mag_to_fp16(input real ax);
      int e;
      real q, fr;
      longint r;
      if (ax >= 65520.0) return 15'h7C00;
      e = 15;
      while (e > -14 && pow2(e) > ax) e--;
      q  = ax / pow2(e - 10);
      r  = longint'($floor(q));
      fr = q - real'(r);
      if (fr > 0.5 || (fr == 0.5 && r[0])) r++;
      return 15'((e + 14) * 1024 + r);
   endfunction

   function automatic logic is_nan(input logic [15:0] h);
      return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
   endfunction

   function automatic logic is_inf(input logic [15:0] h);
      return h[14:0] == 15'h7C00;
   endfunction

   // returns {err, cc[3:0] = {nan,inf,neg,zero}, result}
   function automatic logic [20:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] bb, res;
      real sum;
      logic [3:0] cc;
      if (o > 3'd1) return {1'b1, 4'h0, 16'h0000};
      bb = (o == 3'd1) ? (b ^ 16'h8000) : b;
      if (is_nan(a) || is_nan(bb) || (is_inf(a) && is_inf(bb) && a[15] != bb[15]))
         res = 16'h7E00;
      else if (is_inf(a)) res = a;
      else if (is_inf(bb)) res = bb;
      else begin
         sum = to_real(a) + to_real(bb);
         if (sum == 0.0) res = {a[15] & bb[15], 15'd0};
         else res = {sum < 0.0, mag_to_fp16(sum < 0.0 ? -sum : sum)};
      end
      cc = {is_nan(res), is_inf(res), res[15] & !is_nan(res), res[14:0] == 15'd0};
      return {1'b0, cc, res};
   endfunction

   function automatic logic [W-1:0] expect_entry(input logic [2:0] o, input logic [15:0] a,
                                                 input logic [15:0] b, input logic [TAG_W-1:0] t);
      logic [20:0] m = model(o, a, b);
      return {m[20], t, m[19:0]};
   endfunction

   // scoreboard / compare process
   always @(negedge clock) begin
      if (!reset_L) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            check("slot_hold", 32'({outValid, outErr, tagOut, condCodes, fpuOut}), 32'(snap));
         if (outValid && outReady) begin
            xfer_count++;
            if (exp_q.size() == 0) check("unexpected_result", 32'(tagOut), 32'hFFFF_FFFF);
            else check("result", 32'({outErr, tagOut, condCodes, fpuOut}), 32'(exp_q.pop_front()));
         end
         if (inValid && inReady) exp_q.push_back(expect_entry(op, fpuIn1, fpuIn2, tagIn));
         stall_prev = outValid && !outReady;
         snap       = {outValid, outErr, tagOut, condCodes, fpuOut};
      end
   end

   // driver tasks (called and returning one time unit after a rising edge)
   task automatic send(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [TAG_W-1:0] t, input bit hold);
      bit ok = 1'b0;
      int k = 0;
      inValid = 1'b1; op = o; fpuIn1 = a; fpuIn2 = b; tagIn = t;
      while (!ok && k < 100) begin
         @(negedge clock);
         ok = inReady;
         k++;
      end
      check("send_accept", 32'(ok), 32'd1);
      @(posedge clock); #1;
      if (!hold) inValid = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clock);
         k++;
      end
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load_vectors();
      // op, a, b, result, cc, err -- hand-computed
      v_op[0]  = 3'd0; v_a[0]  = 16'h3C00; v_b[0]  = 16'h4000; v_res[0]  = 16'h4200; v_cc[0]  = 4'h0; v_err[0]  = 1'b0;
      v_op[1]  = 3'd1; v_a[1]  = 16'h4200; v_b[1]  = 16'h3C00; v_res[1]  = 16'h4000; v_cc[1]  = 4'h0; v_err[1]  = 1'b0;
      v_op[2]  = 3'd1; v_a[2]  = 16'h3C00; v_b[2]  = 16'h3C00; v_res[2]  = 16'h0000; v_cc[2]  = 4'h1; v_err[2]  = 1'b0;
      v_op[3]  = 3'd0; v_a[3]  = 16'h7BFF; v_b[3]  = 16'h7BFF; v_res[3]  = 16'h7C00; v_cc[3]  = 4'h4; v_err[3]  = 1'b0;
      v_op[4]  = 3'd0; v_a[4]  = 16'h0001; v_b[4]  = 16'h0001; v_res[4]  = 16'h0002; v_cc[4]  = 4'h0; v_err[4]  = 1'b0;
      v_op[5]  = 3'd0; v_a[5]  = 16'h3C00; v_b[5]  = 16'h1000; v_res[5]  = 16'h3C00; v_cc[5]  = 4'h0; v_err[5]  = 1'b0;
      v_op[6]  = 3'd0; v_a[6]  = 16'h3C01; v_b[6]  = 16'h1000; v_res[6]  = 16'h3C02; v_cc[6]  = 4'h0; v_err[6]  = 1'b0;
      v_op[7]  = 3'd0; v_a[7]  = 16'h7E00; v_b[7]  = 16'h3C00; v_res[7]  = 16'h7E00; v_cc[7]  = 4'h8; v_err[7]  = 1'b0;
      v_op[8]  = 3'd1; v_a[8]  = 16'h7C00; v_b[8]  = 16'h7C00; v_res[8]  = 16'h7E00; v_cc[8]  = 4'h8; v_err[8]  = 1'b0;
      v_op[9]  = 3'd0; v_a[9]  = 16'hC000; v_b[9]  = 16'h3C00; v_res[9]  = 16'hBC00; v_cc[9]  = 4'h2; v_err[9]  = 1'b0;
      v_op[10] = 3'd1; v_a[10] = 16'h0400; v_b[10] = 16'h0001; v_res[10] = 16'h03FF; v_cc[10] = 4'h0; v_err[10] = 1'b0;
      v_op[11] = 3'd0; v_a[11] = 16'hFC00; v_b[11] = 16'h3C00; v_res[11] = 16'hFC00; v_cc[11] = 4'h6; v_err[11] = 1'b0;
      v_op[12] = 3'd0; v_a[12] = 16'h8000; v_b[12] = 16'h8000; v_res[12] = 16'h8000; v_cc[12] = 4'h3; v_err[12] = 1'b0;
      v_op[13] = 3'd0; v_a[13] = 16'h4500; v_b[13] = 16'h4500; v_res[13] = 16'h4900; v_cc[13] = 4'h0; v_err[13] = 1'b0;
      v_op[14] = 3'd1; v_a[14] = 16'h3C00; v_b[14] = 16'h4000; v_res[14] = 16'hBC00; v_cc[14] = 4'h2; v_err[14] = 1'b0;
      v_op[15] = 3'd2; v_a[15] = 16'h4000; v_b[15] = 16'h4000; v_res[15] = 16'h0000; v_cc[15] = 4'h0; v_err[15] = 1'b1;
      v_op[16] = 3'd3; v_a[16] = 16'h4000; v_b[16] = 16'h3C00; v_res[16] = 16'h0000; v_cc[16] = 4'h0; v_err[16] = 1'b1;
      v_op[17] = 3'd5; v_a[17] = 16'h4000; v_b[17] = 16'h0001; v_res[17] = 16'h0000; v_cc[17] = 4'h0; v_err[17] = 1'b1;
   endtask

   initial begin
      int x0;
      reset_L = 1'b0; inValid = 1'b0; outReady = 1'b0;
      op = 3'd0; fpuIn1 = 16'h0; fpuIn2 = 16'h0; tagIn = '0;
      load_vectors();
      for (int i = 0; i < NV; i++)
         check($sformatf("model_pin_%0d", i), 32'(model(v_op[i], v_a[i], v_b[i])),
               32'({v_err[i], v_cc[i], v_res[i]}));

      #1;
      check("reset_outs", 32'({outValid, outErr, tagOut, condCodes, fpuOut}), 32'd0);
      check("reset_occ", 32'(occupancy), 32'd0);
      check("reset_inready", 32'(inReady), 32'd0);
      repeat (2) @(posedge clock);
      #2 reset_L = 1'b1;
      #1 check("inready_before_clock", 32'(inReady), 32'd0);
      @(posedge clock); #1;
      check("inready_after_clock", 32'(inReady), 32'd1);

      // latency: ADD 1.0 + 2.0
      outReady = 1'b1;
      inValid = 1'b1; op = 3'd0; fpuIn1 = 16'h3C00; fpuIn2 = 16'h4000; tagIn = 4'd3;
      @(posedge clock); #1;
      inValid = 1'b0;
      check("lat_edge1_valid", 32'(outValid), 32'd0);
      check("lat_edge1_occ", 32'(occupancy), 32'd1);
      @(posedge clock); #1;
      check("lat_edge2", 32'({outValid, outErr, tagOut, fpuOut}), 32'({1'b1, 1'b0, 4'd3, 16'h4200}));
      check("lat_edge2_occ", 32'(occupancy), 32'd0);
      wait_drain();

      // vector table streamed back to back
      for (int i = 0; i < NV; i++) send(v_op[i], v_a[i], v_b[i], 4'(i), 1'b1);
      inValid = 1'b0;
      wait_drain();

      // fill with the slot stalled
      outReady = 1'b0;
      for (int i = 0; i < 4; i++) send(3'd0, 16'h3C00, 16'(16'h3C00 + 16'(i)), 4'(i), 1'b0);
      check("fill4_occ", 32'(occupancy), 32'd3);
      check("fill4_valid", 32'(outValid), 32'd1);
      send(3'd1, 16'h4400, 16'h3C00, 4'd4, 1'b0);
      check("fill5_occ", 32'(occupancy), 32'd4);
      check("fill5_inready", 32'(inReady), 32'd0);
      inValid = 1'b1; op = 3'd0; tagIn = 4'd5;
      @(negedge clock);
      check("full_block", 32'(inReady), 32'd0);
      @(posedge clock); #1;
      inValid = 1'b0;
      check("full_block_occ", 32'(occupancy), 32'd4);
      outReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("drain_rate", 32'(outValid), 32'd1);
      end
      @(negedge clock);
      check("drain_done", 32'(outValid), 32'd0);
      @(posedge clock); #1;
      check("drain_q", 32'(exp_q.size()), 32'd0);

      // unsupported op then a normal ADD
      send(3'd2, 16'h4000, 16'h4000, 4'd7, 1'b0);
      @(posedge clock); #1;
      check("mul_err", 32'({outValid, outErr, condCodes, fpuOut, tagOut}),
            32'({1'b1, 1'b1, 4'h0, 16'h0000, 4'd7}));
      send(3'd0, 16'h3C00, 16'h3C00, 4'd8, 1'b0);
      @(posedge clock); #1;
      check("after_err_add", 32'({outErr, tagOut, fpuOut}), 32'({1'b0, 4'd8, 16'h4000}));
      wait_drain();

      // 16-deep continuous stream, pointers wrap
      x0 = xfer_count;
      for (int i = 0; i < 16; i++) begin
         send(3'd0, 16'(16'h3800 + 16'(i * 64)), 16'(16'h4100 + 16'(i * 3)), 4'(i), 1'b1);
         check("stream_occ", 32'(occupancy <= 3'd1), 32'd1);
         if (i >= 1) check("stream_rate", 32'(outValid), 32'd1);
      end
      inValid = 1'b0;
      wait_drain();
      check("stream_count", 32'(xfer_count - x0), 32'd16);

      // async reset with work in flight
      outReady = 1'b0;
      for (int i = 0; i < 4; i++) send(3'd0, 16'h4000, 16'h4000, 4'(i + 1), 1'b0);
      check("pre_reset_occ", 32'(occupancy), 32'd3);
      check("pre_reset_valid", 32'(outValid), 32'd1);
      #2 reset_L = 1'b0;
      exp_q.delete();
      #1;
      check("async_reset_outs", 32'({outValid, outErr, tagOut, condCodes, fpuOut}), 32'd0);
      check("async_reset_occ", 32'(occupancy), 32'd0);
      check("async_reset_inready", 32'(inReady), 32'd0);
      repeat (2) @(posedge clock);
      #2 reset_L = 1'b1;
      outReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("no_stale", 32'(outValid), 32'd0);
      end
      @(posedge clock); #1;
      send(3'd0, 16'h4500, 16'h4500, 4'd9, 1'b0);
      wait_drain();
      repeat (2) @(posedge clock);
      #1 check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
